audio_sample_pacer: RTL and testbench

- Downstream of the flash/SDRAM sample reader: takes 16-bit audio samples it produces and buffers them in a small FIFO.
- Pops one sample per sample-rate tick and writes it to both channels of the audio codec output FIFO.
- Handshakes with the codec using audio_out_allowed / write_audio_out.
- Decouples bursty memory reads from the fixed playback rate and counts underruns.

---
 rtl/audio_sample_pacer.sv | 147 ++++++++++++++
 tb/tb_audio_sample_pacer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_pacer.sv
// Paces buffered audio samples out to the codec at a fixed sample rate.
// A small FIFO absorbs bursty reader traffic; one sample per tick goes to both codec channels.
module audio_sample_pacer #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 8,
  parameter int CLK_DIV = 2272
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        sample_in,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  input  logic                     enable,
  input  logic                     audio_out_allowed,
  output logic                     write_audio_out,
  output logic [DATA_W-1:0]        left_data,
  output logic [DATA_W-1:0]        right_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              underrun_count,
  output logic                     codec_stall,
  output logic [1:0]               state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  // State encoding is visible on state_dbg: 0 IDLE, 1 WAIT_TICK, 2 WAIT_CODEC, 3 WRITE.
  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_TICK  = 2'd1,
    S_WAIT_CODEC = 2'd2,
    S_WRITE      = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [DW-1:0]       div_cnt;
  logic                tick;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       count, count_next;
  logic                full, empty, push, pop;
  logic                load, stall_set;
  logic [DATA_W-1:0]   data_q;
  logic [15:0]         underrun_q, underrun_next;
  logic                write_q, stall_q;

  // Sample-rate divider: free-runs only while playback is enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (!enable || div_cnt == DIV_MAX) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = enable && (div_cnt == DIV_MAX);

  // Handshake: a sample transfers on any cycle where sample_valid && sample_ready;
  // sample_ready reflects only the registered full flag, so a same-cycle pop never frees a slot early.
  assign full         = (count == LW'(DEPTH));
  assign empty        = (count == '0);
  assign sample_ready = !full;
  assign push         = sample_valid && !full;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    pop        = 1'b0;
    stall_set  = 1'b0;
    if (!enable) begin
      state_next = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: state_next = S_WAIT_TICK;
        S_WAIT_TICK: begin
          if (tick) begin
            load       = 1'b1;
            pop        = !empty;
            state_next = S_WAIT_CODEC;
          end
        end
        S_WAIT_CODEC: begin
          if (audio_out_allowed) state_next = S_WRITE;
          stall_set = tick;
        end
        S_WRITE: begin
          state_next = S_WAIT_TICK;
          stall_set  = tick;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // An empty tick replays the previous sample rather than outputting silence.
  assign underrun_next = (load && empty && underrun_q != 16'hFFFF) ? underrun_q + 16'd1 : underrun_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_q     <= '0;
      underrun_q <= '0;
      write_q    <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      underrun_q <= underrun_next;
      write_q    <= (state_next == S_WRITE);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        data_q <= mem[rd_ptr];
      end
      if (!enable)        stall_q <= 1'b0;
      else if (stall_set) stall_q <= 1'b1;
    end
  end

  assign write_audio_out = write_q;
  assign left_data       = data_q;
  assign right_data      = data_q;
  assign fifo_level      = count;
  assign underrun_count  = underrun_q;
  assign codec_stall     = stall_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Bench for audio_sample_pacer: directed scenarios plus a random phase, all
// compared every cycle against a queue-based playback model.
module tb_audio_sample_pacer;
  localparam int DW      = 16;
  localparam int DEPTH   = 4;
  localparam int CLK_DIV = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic          enable = 1'b0;
  logic          audio_out_allowed = 1'b0;
  logic          write_audio_out;
  logic [DW-1:0] left_data, right_data;
  logic [2:0]    fifo_level;
  logic [15:0]   underrun_count;
  logic          codec_stall;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  audio_sample_pacer #(.DATA_W(DW), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .enable(enable), .audio_out_allowed(audio_out_allowed),
    .write_audio_out(write_audio_out), .left_data(left_data), .right_data(right_data),
    .fifo_level(fifo_level), .underrun_count(underrun_count), .codec_stall(codec_stall),
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: sample queue, count of enabled edges, and a pending-write flag.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wr_log[$];
  int            m_run = 0;
  bit            m_pending = 0, m_strobe = 0, m_stall = 0;
  logic [DW-1:0] m_out = '0;
  logic [15:0]   m_under = '0;
  int            strobes = 0;

  always @(posedge clk or negedge reset) begin : model
    bit ready, tick, can_load, new_strobe;
    if (!reset) begin
      m_q.delete();
      exp_q.delete();
      m_run = 0; m_pending = 0; m_strobe = 0; m_stall = 0;
      m_out = '0; m_under = '0;
    end else begin
      ready      = m_q.size() < DEPTH;
      can_load   = !m_pending && !m_strobe;
      new_strobe = 0;
      tick       = 0;
      if (enable) begin
        m_run++;
        tick = (m_run % CLK_DIV) == 0;
        if (m_pending && audio_out_allowed) begin
          m_pending  = 0;
          new_strobe = 1;
          exp_q.push_back(m_out);
        end
        if (tick) begin
          if (can_load) begin
            if (m_q.size() > 0) m_out = m_q.pop_front();
            else if (m_under != 16'hFFFF) m_under = m_under + 16'd1;
            m_pending = 1;
          end else begin
            m_stall = 1;
          end
        end
      end else begin
        m_run = 0; m_pending = 0; m_stall = 0;
      end
      m_strobe = new_strobe;
      if (sample_valid && ready) m_q.push_back(sample_in);
    end
  end

  always @(negedge clk) begin : monitor
    chk("sample_ready", 32'(sample_ready), (m_q.size() < DEPTH) ? 32'd1 : 32'd0);
    chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    chk("write_audio_out", 32'(write_audio_out), 32'(m_strobe));
    chk("left_data", 32'(left_data), 32'(m_out));
    chk("right_data", 32'(right_data), 32'(m_out));
    chk("underrun_count", 32'(underrun_count), 32'(m_under));
    chk("codec_stall", 32'(codec_stall), 32'(m_stall));
    if (m_pending) chk("state_wait_codec", 32'(state_dbg), 32'd2);
    if (write_audio_out === 1'b1) begin
      strobes++;
      wr_log.push_back(left_data);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard: got write of %0h expected no write", left_data);
      end else begin
        chk("scoreboard", 32'(left_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stimulus
    int base;
    int waited;
    logic [DW-1:0] seq [3];
    seq[0] = 16'h5555; seq[1] = 16'hAAAA; seq[2] = 16'h1234;

    // Reset state
    step(3);
    chk("rst_write", 32'(write_audio_out), 32'd0);
    chk("rst_left", 32'(left_data), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ready", 32'(sample_ready), 32'd1);
    chk("rst_underrun", 32'(underrun_count), 32'd0);
    chk("rst_stall", 32'(codec_stall), 32'd0);
    reset = 1'b1;
    step(1);

    // Prefill three samples while idle, then play them out and into underrun
    for (int i = 0; i < 3; i++) begin
      sample_in = seq[i]; sample_valid = 1'b1;
      step(1);
    end
    sample_valid = 1'b0;
    chk("prefill_level", 32'(fifo_level), 32'd3);
    wr_log.delete();
    base = strobes;
    enable = 1'b1; audio_out_allowed = 1'b1;
    step(23);
    chk("play_strobes", 32'(strobes - base), 32'd5);
    if (wr_log.size() >= 5) begin
      chk("play_seq0", 32'(wr_log[0]), 32'h5555);
      chk("play_seq1", 32'(wr_log[1]), 32'hAAAA);
      chk("play_seq2", 32'(wr_log[2]), 32'h1234);
      chk("hold_seq3", 32'(wr_log[3]), 32'h1234);
      chk("hold_seq4", 32'(wr_log[4]), 32'h1234);
    end else begin
      chk("play_log_size", 32'(wr_log.size()), 32'd5);
    end
    chk("underrun_two", 32'(underrun_count), 32'd2);
    chk("drained_level", 32'(fifo_level), 32'd0);

    // Saturation of the underrun counter
    enable = 1'b0;
    force dut.underrun_q = 16'hFFFE;
    m_under = 16'hFFFE;
    step(1);
    release dut.underrun_q;
    step(1);
    chk("underrun_preload", 32'(underrun_count), 32'hFFFE);
    enable = 1'b1;
    step(5);
    chk("underrun_ffff", 32'(underrun_count), 32'hFFFF);
    step(4);
    chk("underrun_sat", 32'(underrun_count), 32'hFFFF);
    chk("hold_1234", 32'(left_data), 32'h1234);

    // Five back-to-back pushes while disabled: fourth fills, fifth held off
    enable = 1'b0;
    step(1);
    base = strobes;
    for (int i = 0; i < 5; i++) begin
      sample_in = DW'($urandom); sample_valid = 1'b1;
      step(1);
      if (i == 3) begin
        chk("full_ready", 32'(sample_ready), 32'd0);
        chk("full_level", 32'(fifo_level), 32'd4);
      end
    end
    sample_valid = 1'b0;
    chk("held_off_level", 32'(fifo_level), 32'd4);
    chk("disabled_no_write", 32'(strobes - base), 32'd0);

    // Codec back-pressure: later ticks are dropped and flagged
    base = strobes;
    enable = 1'b1; audio_out_allowed = 1'b0;
    step(14);
    chk("stall_flag", 32'(codec_stall), 32'd1);
    chk("stall_state", 32'(state_dbg), 32'd2);
    chk("stall_level", 32'(fifo_level), 32'd3);
    chk("stall_no_write", 32'(strobes - base), 32'd0);
    audio_out_allowed = 1'b1;
    step(2);
    chk("stall_one_write", 32'(strobes - base), 32'd1);
    chk("stall_level_after", 32'(fifo_level), 32'd3);
    enable = 1'b0;
    step(1);

    // Push against a full FIFO in the same cycle as a tick-pop
    sample_in = DW'($urandom); sample_valid = 1'b1;
    step(1);
    sample_valid = 1'b0;
    chk("refill_level", 32'(fifo_level), 32'd4);
    enable = 1'b1;
    step(3);
    chk("pre_pop_ready", 32'(sample_ready), 32'd0);
    chk("pre_pop_level", 32'(fifo_level), 32'd4);
    sample_in = DW'($urandom); sample_valid = 1'b1;
    step(1);
    chk("pop_cycle_level", 32'(fifo_level), 32'd3);
    chk("pop_cycle_ready", 32'(sample_ready), 32'd1);
    step(1);
    chk("push_next_level", 32'(fifo_level), 32'd4);
    chk("push_next_ready", 32'(sample_ready), 32'd0);
    sample_valid = 1'b0; audio_out_allowed = 1'b0;

    // Reset while a write is pending with three samples queued
    waited = 0;
    while (!(m_pending && m_q.size() == 3) && waited < 40) begin
      step(1);
      waited++;
    end
    chk("reach_wait_codec_timeout", 32'(waited < 40), 32'd1);
    chk("pre_reset_state", 32'(state_dbg), 32'd2);
    chk("pre_reset_level", 32'(fifo_level), 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("async_write", 32'(write_audio_out), 32'd0);
    chk("async_left", 32'(left_data), 32'd0);
    chk("async_right", 32'(right_data), 32'd0);
    chk("async_level", 32'(fifo_level), 32'd0);
    chk("async_underrun", 32'(underrun_count), 32'd0);
    chk("async_stall", 32'(codec_stall), 32'd0);
    chk("async_ready", 32'(sample_ready), 32'd1);
    audio_out_allowed = 1'b1;
    step(2);
    reset = 1'b1;
    step(3);
    chk("no_tick_yet", 32'(underrun_count), 32'd0);
    step(1);
    chk("first_tick", 32'(underrun_count), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      sample_valid      = ($urandom_range(0, 2) == 0);
      sample_in         = DW'($urandom);
      audio_out_allowed = ($urandom_range(0, 3) != 0);
      enable            = ($urandom_range(0, 49) != 0);
      step(1);
    end
    sample_valid = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
